// File: rtl/text_pixel_gen_pkg.sv
// Shared widths, pipeline payload and cell-address helper for the text pixel generator.
// The optional block-cursor overlay is enabled by defining CURSOR_TEXT_EN.
package text_pixel_gen_pkg;

  localparam int unsigned TADDR_W = 12;
  localparam int unsigned FADDR_W = 11;
  localparam int unsigned COL_W   = 7;
  localparam int unsigned ROW_W   = 5;
  localparam int unsigned RGB_W   = 3;

  // Per-pixel side information carried alongside the buffer/ROM lookups.
  typedef struct packed {
`ifdef CURSOR_TEXT_EN
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
`endif
    logic [2:0]       xbit;
    logic [3:0]       vrow;
    logic             hsync;
    logic             vsync;
    logic             blank;
  } pipe_t;

  // Blank is held high through reset so nothing is drawn until real data arrives.
  localparam pipe_t PIPE_RST = '{blank: 1'b1, default: '0};

  // Row-major cell address for an 80-column buffer: row*80 = row*64 + row*16.
  function automatic logic [TADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
    cell_addr = TADDR_W'({row, 6'b0}) + TADDR_W'({row, 4'b0}) + TADDR_W'(col);
  endfunction

endpackage

// File: rtl/text_pixel_gen_cursor_blink.sv
// Block-cursor overlay: frame counter, blink phase and cell compare.
// Only present when CURSOR_TEXT_EN is defined.
`ifdef CURSOR_TEXT_EN
module text_pixel_gen_cursor_blink
  import text_pixel_gen_pkg::*;
(
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             vsync_i,
  input  logic [COL_W-1:0] cell_x_i,
  input  logic [ROW_W-1:0] cell_y_i,
  input  logic [COL_W-1:0] cursor_x_i,
  input  logic [ROW_W-1:0] cursor_y_i,
  output logic             invert_c
);

  logic [5:0] frame_cnt;
  logic       vsync_q;

  // Count vsync falling edges; bit 5 gives a ~0.5 s on/off phase at 60 Hz.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      frame_cnt <= '0;
      vsync_q   <= 1'b0;
    end else begin
      vsync_q <= vsync_i;
      if (vsync_q && !vsync_i) begin
        frame_cnt <= frame_cnt + 6'd1;
      end
    end
  end

  assign invert_c = frame_cnt[5] && (cell_x_i == cursor_x_i) && (cell_y_i == cursor_y_i);

endmodule
`endif

// File: rtl/text_pixel_gen.sv
// Character-mode pixel generator: beam position -> text buffer -> font ROM -> pixel.
// Fixed 3-clock latency from hcount_i/syncs to rgb_o/syncs, free-running pipeline.
// Define CURSOR_TEXT_EN to add the blinking block-cursor overlay and its ports.
module text_pixel_gen
  import text_pixel_gen_pkg::*;
#(
  parameter logic [RGB_W-1:0] FG_RGB = 3'b111,
  parameter logic [RGB_W-1:0] BG_RGB = 3'b000
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [9:0]         hcount_i,
  input  logic [9:0]         vcount_i,
  input  logic               hsync_i,
  input  logic               vsync_i,
  input  logic               blank_i,
  output logic [TADDR_W-1:0] taddr_o,
  input  logic [7:0]         char_i,
  output logic [FADDR_W-1:0] faddr_o,
  input  logic [7:0]         font_i,
  output logic [RGB_W-1:0]   rgb_o,
  output logic               hsync_o,
  output logic               vsync_o
`ifdef CURSOR_TEXT_EN
  ,
  input  logic [COL_W-1:0]   cursor_x_i,
  input  logic [ROW_W-1:0]   cursor_y_i
`endif
);

  pipe_t            s0_c;
  pipe_t            d1;
  pipe_t            d2;
  logic [COL_W-1:0] col_c;
  logic [ROW_W-1:0] row_c;
  logic             glyph_bit_c;
  logic             invert_c;
  logic             pix_on_c;
  logic             unused_bits;

  // Bit 9 of vcount never reaches the visible rows; bit 7 of the char code is ignored.
  assign unused_bits = ^{vcount_i[9], char_i[7]};

  assign col_c = hcount_i[9:3];
  assign row_c = vcount_i[8:4];

  // Stage 0 payload: in-cell pixel position plus timing signals.
  always_comb begin
    s0_c       = PIPE_RST;
`ifdef CURSOR_TEXT_EN
    s0_c.col   = col_c;
    s0_c.row   = row_c;
`endif
    s0_c.xbit  = hcount_i[2:0];
    s0_c.vrow  = vcount_i[3:0];
    s0_c.hsync = hsync_i;
    s0_c.vsync = vsync_i;
    s0_c.blank = blank_i;
  end

  // Stage 0: text-buffer address, clamped to 0 outside the visible area.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      taddr_o <= '0;
      d1      <= PIPE_RST;
    end else begin
      taddr_o <= blank_i ? '0 : cell_addr(row_c, col_c);
      d1      <= s0_c;
    end
  end

  // Stage 1: character code plus glyph row forms the font address.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      faddr_o <= '0;
      d2      <= PIPE_RST;
    end else begin
      faddr_o <= {char_i[6:0], d1.vrow};
      d2      <= d1;
    end
  end

`ifdef CURSOR_TEXT_EN
  text_pixel_gen_cursor_blink u_cursor_blink (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .vsync_i    (vsync_i),
    .cell_x_i   (d2.col),
    .cell_y_i   (d2.row),
    .cursor_x_i (cursor_x_i),
    .cursor_y_i (cursor_y_i),
    .invert_c   (invert_c)
  );
`else
  assign invert_c = 1'b0;
`endif

  // Leftmost pixel is bit 7 of the glyph row.
  assign glyph_bit_c = font_i[3'd7 - d2.xbit];
  assign pix_on_c    = glyph_bit_c ^ invert_c;

  // Stage 2: pixel colour and delayed syncs; black while blanked.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rgb_o   <= '0;
      hsync_o <= 1'b1;
      vsync_o <= 1'b1;
    end else begin
      rgb_o   <= d2.blank ? '0 : (pix_on_c ? FG_RGB : BG_RGB);
      hsync_o <= d2.hsync;
      vsync_o <= d2.vsync;
    end
  end

endmodule

// File: tb/tb_text_pixel_gen.sv
// Directed self-checking bench for text_pixel_gen (cursor section needs CURSOR_TEXT_EN).
module tb_text_pixel_gen;

  logic        clk;
  logic        rstn;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        hsync;
  logic        vsync;
  logic        blank;
  logic [11:0] taddr;
  logic [7:0]  char_in;
  logic [10:0] faddr;
  logic [7:0]  font;
  logic [2:0]  rgb;
  logic        hsync_out;
  logic        vsync_out;
`ifdef CURSOR_TEXT_EN
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic hs_hist [0:119];
  logic vs_hist [0:119];

  text_pixel_gen dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .hcount_i   (hcount),
    .vcount_i   (vcount),
    .hsync_i    (hsync),
    .vsync_i    (vsync),
    .blank_i    (blank),
    .taddr_o    (taddr),
    .char_i     (char_in),
    .faddr_o    (faddr),
    .font_i     (font),
    .rgb_o      (rgb),
    .hsync_o    (hsync_out),
    .vsync_o    (vsync_out)
`ifdef CURSOR_TEXT_EN
    ,
    .cursor_x_i (cursor_x),
    .cursor_y_i (cursor_y)
`endif
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef CURSOR_TEXT_EN
  task automatic vsync_pulse();
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
  endtask
`endif

  initial begin
    rstn    = 1'b0;
    hcount  = 10'd0;
    vcount  = 10'd0;
    hsync   = 1'b1;
    vsync   = 1'b1;
    blank   = 1'b1;
    char_in = 8'h00;
    font    = 8'h00;
`ifdef CURSOR_TEXT_EN
    cursor_x = 7'd2;
    cursor_y = 5'd1;
`endif

    // Reset state
    tick();
    tick();
    check_eq("rst_rgb",   32'(rgb),       32'(0));
    check_eq("rst_hsync", 32'(hsync_out), 32'(1));
    check_eq("rst_vsync", 32'(vsync_out), 32'(1));
    check_eq("rst_taddr", 32'(taddr),     32'(0));
    check_eq("rst_faddr", 32'(faddr),     32'(0));
    rstn = 1'b1;

    // Address map
    blank  = 1'b0;
    hcount = 10'd100; vcount = 10'd40;
    tick();
    check_eq("taddr_100_40", 32'(taddr), 32'(172));
    hcount = 10'd639; vcount = 10'd479;
    tick();
    check_eq("taddr_639_479", 32'(taddr), 32'(2399));
    hcount = 10'd8; vcount = 10'd16;
    tick();
    check_eq("taddr_8_16", 32'(taddr), 32'(81));
    hcount = 10'd700; vcount = 10'd100; blank = 1'b1;
    tick();
    check_eq("taddr_blank_clamp", 32'(taddr), 32'(0));

    // Asynchronous reset in the middle of a line
    hcount = 10'd639; vcount = 10'd479; blank = 1'b0; hsync = 1'b0;
    tick();
    tick();
    tick();
    check_eq("pre_rst_taddr", 32'(taddr),     32'(2399));
    check_eq("pre_rst_hsync", 32'(hsync_out), 32'(0));
    #15;
    rstn = 1'b0;
    #1;
    check_eq("async_rst_taddr", 32'(taddr),     32'(0));
    check_eq("async_rst_hsync", 32'(hsync_out), 32'(1));
    check_eq("async_rst_vsync", 32'(vsync_out), 32'(1));
    check_eq("async_rst_rgb",   32'(rgb),       32'(0));
    check_eq("async_rst_faddr", 32'(faddr),     32'(0));
    #5;
    rstn  = 1'b1;
    hsync = 1'b1;

    // Font address
    hcount = 10'd0; vcount = 10'd5; char_in = 8'h41;
    tick();
    tick();
    check_eq("faddr_41_r5", 32'(faddr), 32'h415);
    char_in = 8'hC1;
    tick();
    check_eq("faddr_c1_r5", 32'(faddr), 32'h415);
    vcount = 10'd31; char_in = 8'h7A;
    tick();
    tick();
    check_eq("faddr_7a_r15", 32'(faddr), 32'h7AF);

    // Pixel select: edge pixels lit, inner pixels dark, 3-clock latency
    vcount = 10'd0; font = 8'b1000_0001;
    for (int i = 0; i < 12; i++) begin
      hcount = 10'(i);
      tick();
      if (i >= 2) begin
        int x;
        x = (i - 2) % 8;
        check_eq($sformatf("pix_x%0d", i - 2), 32'(rgb), 32'((x == 0 || x == 7) ? 7 : 0));
      end
    end

    // Blank forces black even with a solid glyph
    font = 8'hFF; blank = 1'b1; hcount = 10'd700;
    tick();
    tick();
    tick();
    check_eq("blank_solid_glyph", 32'(rgb), 32'(0));
    blank = 1'b0; hcount = 10'd0;
    tick();
    tick();
    check_eq("blank_tail", 32'(rgb), 32'(0));
    tick();
    check_eq("unblank_fg", 32'(rgb), 32'(7));

    // Sync alignment: 96-clock hsync pulse and short vsync pulse, shifted 3 clocks
    for (int i = 0; i < 120; i++) begin
      hs_hist[i] = !(i >= 10 && i < 106);
      vs_hist[i] = !(i >= 50 && i < 53);
      hsync  = hs_hist[i];
      vsync  = vs_hist[i];
      hcount = 10'(i);
      tick();
      if (i >= 2) begin
        check_eq($sformatf("hsync_d%0d", i - 2), 32'(hsync_out), 32'(hs_hist[i-2]));
        check_eq($sformatf("vsync_d%0d", i - 2), 32'(vsync_out), 32'(vs_hist[i-2]));
      end
    end
    hsync = 1'b1;
    vsync = 1'b1;

`ifdef CURSOR_TEXT_EN
    // Cursor blink at cell (2,1) with an empty glyph
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    font = 8'h00; blank = 1'b0; hcount = 10'd16; vcount = 10'd16;
    repeat (31) vsync_pulse();
    repeat (3) tick();
    check_eq("cursor_frame31", 32'(rgb), 32'(0));
    vsync_pulse();
    repeat (3) tick();
    check_eq("cursor_frame32", 32'(rgb), 32'(7));
    hcount = 10'd24;
    repeat (3) tick();
    check_eq("cursor_other_cell", 32'(rgb), 32'(0));
    hcount = 10'd16;
    repeat (32) vsync_pulse();
    repeat (3) tick();
    check_eq("cursor_frame64_wrap", 32'(rgb), 32'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
